mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Sequences every unified-memory access (instruction fetch, load, store) between the multicycle ARM controller/datapath and a variable-latency external memory using a req/ack handshake. It latches the address and write data and drives the external bus, and it returns read data. While an access is outstanding it holds the controller FSM with Stall. A bounded-wait timeout raises a sticky bus error instead of hanging the core.

Parameters:
ADDR_WIDTH, 32, width of Adr / mem_addr
DATA_WIDTH, 32, width of WriteData / ReadData / mem_wdata / mem_rdata
TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before abort (>=1)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_rd  input  1  read request from controller (FETCH / MEMRD), held until Done
req_wr  input  1  write request (MemWrite), held until Done
Adr  input  ADDR_WIDTH  access address from datapath address mux
WriteData  input  DATA_WIDTH  store data
ReadData  output  DATA_WIDTH  last completed read data, held until next read completes
Stall  output  1  controller must hold its state while 1
Done  output  1  one-cycle pulse, access finished (ok or error)
bus_err  output  1  sticky timeout flag
mem_req  output  1  external request, registered
mem_we  output  1  external write enable, valid with mem_req
mem_addr  output  ADDR_WIDTH  registered address
mem_wdata  output  DATA_WIDTH  registered write data
mem_ack  input  1  external completion, sampled only in REQ
mem_rdata  input  DATA_WIDTH  valid in cycle mem_ack=1 for reads

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, Done=0, bus_err=0, counter=0. Takes effect immediately mid-transaction; external bus sees mem_req drop.
- States: IDLE, REQ, DONE, ERR (2-bit encoding).
- IDLE: if req_wr|req_rd at a clk edge: latch Adr->mem_addr, WriteData->mem_wdata, mem_we=req_wr, counter=0, mem_req=1, go REQ. Both asserted: write wins (mem_we=1). mem_ack in IDLE is ignored.
- REQ: mem_req, mem_we, mem_addr and mem_wdata stay stable. counter increments each cycle without ack.
  - mem_ack=1: mem_req=0 next edge; if read, ReadData<=mem_rdata; go DONE.
  - counter==TIMEOUT-1 and no ack: mem_req=0; bus_err<=1; go ERR.
  - ack wins over timeout in the same cycle.
- DONE: Done=1 for this cycle only. Request inputs ignored. Next state IDLE.
- ERR: Done=1 for this cycle only. ReadData unchanged. Next state IDLE.
- bus_err: set only from REQ timeout; cleared only by reset; does not block later accesses.
- Stall = (req_rd|req_wr) & ~(state==DONE | state==ERR). Combinational, so the controller advances on the cycle Done is high.
- Latency: request seen at edge 0 -> mem_req high from cycle 1. Ack seen at edge k (k>=1) -> Done high during cycle k+1. A zero-wait memory acking the first mem_req cycle gives a Done at cycle 2.
- Withdrawing req_* while in REQ does not abort the access; completes normally (protocol violation upstream, but the bus stays clean).
- Counter width: clog2(TIMEOUT+1); no wrap possible since exit at TIMEOUT-1.
- Back-to-back: a new request held into the cycle after DONE starts a fresh access (mem_req rises one cycle after returning to IDLE).

Test Plan:
- Zero-wait read: req_rd=1, Adr=0x00000010, mem_ack on first mem_req cycle, mem_rdata=0xE2802005 -> mem_req high 1 cycle, mem_we=0, Done at cycle 2, ReadData=0xE2802005, Stall 1 in cycles 0-1, 0 in cycle 2.
- 3-wait write: req_wr=1, Adr=0x100, WriteData=0x0000002A, ack after 3 idle cycles -> mem_addr=0x100, mem_wdata=0x2A, mem_we=1 stable 4 cycles, ReadData unchanged, single Done pulse.
- Timeout: req_rd=1, mem_ack never -> mem_req high exactly TIMEOUT(15) cycles, bus_err=1 thereafter, Done pulse, next read with ack completes normally with bus_err still 1.
- Reset mid-access: reset=0 during REQ (asynchronous, between edges) -> mem_req, Done, bus_err, ReadData all 0 immediately; after release with req_rd held, new access starts from IDLE.
- Simultaneous rd/wr: req_rd=req_wr=1 -> mem_we=1 (write chosen), ReadData not updated.
- Spurious ack: mem_ack=1 while IDLE with no request -> no state change, Done=0, ReadData unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Unified-memory access sequencer between the multicycle controller and a
// variable-latency req/ack memory. Latches address/data, drives the bus,
// returns read data, stalls the controller and aborts on a bounded wait.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access outstanding, waiting for req_rd / req_wr
// REQ   | mem_req driven, waiting for mem_ack or timeout
// DONE  | access completed normally, Done pulse
// ERR   | access aborted on timeout, Done pulse, bus_err now set
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] Adr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          start;
    logic          ack_ok;
    logic          timeout;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ack_ok    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req_rd | req_wr) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // ack has priority over an expiring counter in the same cycle
                if (mem_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = DONE;
                end else if (count == CW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drivers, wait counter, read-data capture and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadData  <= '0;
            bus_err   <= 1'b0;
            count     <= '0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= req_wr;
            mem_addr  <= Adr;
            mem_wdata <= WriteData;
            count     <= '0;
        end else if (ack_ok) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData <= mem_rdata;
        end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
        end else if (state == REQ) begin
            count <= count + 1'b1;
        end
    end

    // Done is decoded from state so it lasts exactly one cycle; Stall drops in
    // that same cycle so the controller advances while Done is high.
    always_comb begin
        Done  = (state == DONE) || (state == ERR);
        Stall = (req_rd | req_wr) & ~Done;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of accesses driven against a
// req/ack memory responder, expected results kept in a scoreboard queue, plus
// hand-written reset / spurious-ack / back-to-back sequences.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .Adr      (Adr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Stall    (Stall),
        .Done     (Done),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          waits;     // idle REQ cycles before ack; >=TIMEOUT means never
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_nreq;  // cycles mem_req stays high
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          nreq;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n_req;
        bit   got;
        req_rd    = v.rd;
        req_wr    = v.wr;
        Adr       = v.adr;
        WriteData = v.wdata;
        mem_ack   = 1'b0;
        #1;
        chk("stall_on_request", 32'(Stall), 32'd1);
        e.we    = v.exp_we;
        e.addr  = v.adr;
        e.wdata = v.wdata;
        e.rd    = v.exp_rd;
        e.err   = v.exp_err;
        e.nreq  = v.exp_nreq;
        sb.push_back(e);
        n_req = 0;
        got   = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (Done) begin
                got = 1'b1;
                e   = sb.pop_front();
                chk("readdata", ReadData, e.rd);
                chk("bus_err", 32'(bus_err), 32'(e.err));
                chk("req_cycles", 32'(n_req), 32'(e.nreq));
                chk("stall_at_done", 32'(Stall), 32'd0);
                chk("req_low_at_done", 32'(mem_req), 32'd0);
            end else begin
                chk("stall_busy", 32'(Stall), 32'd1);
                if (mem_req) begin
                    n_req++;
                    chk("mem_we", 32'(mem_we), 32'(sb[0].we));
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_wdata", mem_wdata, sb[0].wdata);
                    if (n_req == v.waits + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                    end
                end
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no Done within 40 cycles, required one");
            if (sb.size() > 0) void'(sb.pop_front());
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", 32'(Done), 32'd0);
        chk("readdata_hold", ReadData, v.exp_rd);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 0,  32'hE280_2005, 1'b0, 32'hE280_2005, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h2A, 3, 32'hDEAD_BEEF, 1'b1, 32'hE280_2005, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'h55AA, 1, 32'h1234_5678, 1'b1, 32'hE280_2005, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 2,  32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 14, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0, 15};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 99, 32'hFFFF_0000, 1'b0, 32'h1357_9BDF, 1'b1, 15};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b1, 1};

        reset     = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        Adr       = '0;
        WriteData = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;

        // spurious ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_done", 32'(Done), 32'd0);
            chk("spur_mem_req", 32'(mem_req), 32'd0);
            chk("spur_readdata", ReadData, 32'd0);
            chk("spur_stall", 32'(Stall), 32'd0);
        end
        mem_ack = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // asynchronous reset in the middle of REQ, request held through it
        req_rd = 1'b1;
        Adr    = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_done", 32'(Done), 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        chk("arst_readdata", ReadData, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'h0000_0500);
        chk("restart_we", 32'(mem_we), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("restart_done", 32'(Done), 32'd1);
        chk("restart_readdata", ReadData, 32'hCAFE_F00D);
        chk("restart_bus_err", 32'(bus_err), 32'd0);
        chk("restart_stall", 32'(Stall), 32'd0);

        // request still held after Done: back-to-back access
        Adr = 32'h0000_0504;
        @(negedge clk);
        chk("b2b_idle_done", 32'(Done), 32'd0);
        chk("b2b_idle_req", 32'(mem_req), 32'd0);
        chk("b2b_idle_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        chk("b2b_req", 32'(mem_req), 32'd1);
        chk("b2b_addr", mem_addr, 32'h0000_0504);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0F0F_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        req_rd  = 1'b0;
        chk("b2b_done", 32'(Done), 32'd1);
        chk("b2b_readdata", ReadData, 32'h0F0F_1234);
        @(negedge clk);
        chk("b2b_end_done", 32'(Done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
